// File: rtl/regfile_rename_mp.sv
// Multi-port architectural register file with per-register ROB rename tags (register status table).
// Reads combinational with intra-bundle rename bypass (+ commit forwarding under REGFILE_COMMIT_BYPASS_EN); writes 1 cycle.
// Backpressure: rdy=0 freezes all state; misbranch and commits that cycle are dropped, outputs still reflect state.
module regfile_rename_mp #(
  parameter int NREG     = 32,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2,
  localparam int RW      = $clog2(NREG),
  localparam int CW      = $clog2(NREG + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  input  logic                        in_misbranch,
  input  logic [ISSUE_W*RW-1:0]       in_dec_rs1,
  input  logic [ISSUE_W*RW-1:0]       in_dec_rs2,
  input  logic [ISSUE_W*RW-1:0]       in_dec_rd,
  input  logic [ISSUE_W*TAG_W-1:0]    in_dec_tag,
  output logic [ISSUE_W*XLEN-1:0]     out_rs1_value,
  output logic [ISSUE_W*XLEN-1:0]     out_rs2_value,
  output logic [ISSUE_W*TAG_W-1:0]    out_rs1_tag,
  output logic [ISSUE_W*TAG_W-1:0]    out_rs2_tag,
  input  logic [COMMIT_W*RW-1:0]      in_cm_idx,
  input  logic [COMMIT_W*XLEN-1:0]    in_cm_value,
  input  logic [COMMIT_W*TAG_W-1:0]   in_cm_tag,
  output logic [CW-1:0]               out_pending_cnt
);

  logic [XLEN-1:0]  val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [XLEN-1:0]  val_n [NREG];
  logic [TAG_W-1:0] tag_n [NREG];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_n;

  logic [RW-1:0]    rd_idx;
  logic [XLEN-1:0]  rd_val;
  logic [TAG_W-1:0] rd_tag;
`ifdef REGFILE_COMMIT_BYPASS_EN
  logic [TAG_W-1:0] rd_res_tag;
  logic             rd_renamed;
`endif

  // Read path: state, then older-slot renames in the same bundle (youngest wins), then optional commit forward.
  always_comb begin
    out_rs1_value = '0;
    out_rs2_value = '0;
    out_rs1_tag   = '0;
    out_rs2_tag   = '0;
    rd_idx        = '0;
    rd_val        = '0;
    rd_tag        = '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
    rd_res_tag    = '0;
    rd_renamed    = 1'b0;
`endif
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int s = 0; s < 2; s++) begin
        rd_idx = (s == 0) ? in_dec_rs1[j*RW +: RW] : in_dec_rs2[j*RW +: RW];
        rd_val = val_q[rd_idx];
        rd_tag = tag_q[rd_idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
        rd_renamed = 1'b0;
`endif
        for (int i = 0; i < j; i++) begin
          if (in_dec_rd[i*RW +: RW] == rd_idx && in_dec_tag[i*TAG_W +: TAG_W] != '0) begin
            rd_tag = in_dec_tag[i*TAG_W +: TAG_W];
`ifdef REGFILE_COMMIT_BYPASS_EN
            rd_renamed = 1'b1;
`endif
          end
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        rd_res_tag = rd_tag;
        if (!rd_renamed && rdy) begin
          for (int k = 0; k < COMMIT_W; k++) begin
            if (in_cm_idx[k*RW +: RW] == rd_idx && in_cm_tag[k*TAG_W +: TAG_W] == rd_res_tag) begin
              rd_val = in_cm_value[k*XLEN +: XLEN];
              rd_tag = '0;
            end
          end
        end
`endif
        if (rd_idx == '0) begin
          rd_val = '0;
          rd_tag = '0;
        end
        if (s == 0) begin
          out_rs1_value[j*XLEN +: XLEN]  = rd_val;
          out_rs1_tag[j*TAG_W +: TAG_W]  = rd_tag;
        end else begin
          out_rs2_value[j*XLEN +: XLEN]  = rd_val;
          out_rs2_tag[j*TAG_W +: TAG_W]  = rd_tag;
        end
      end
    end
  end

  // Commit clears only when the committing tag is still the live producer; renames applied later so they win.
  always_comb begin
    val_n = val_q;
    tag_n = tag_q;
    cnt_n = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (in_cm_idx[k*RW +: RW] != '0) begin
        val_n[in_cm_idx[k*RW +: RW]] = in_cm_value[k*XLEN +: XLEN];
        if (tag_q[in_cm_idx[k*RW +: RW]] == in_cm_tag[k*TAG_W +: TAG_W] ||
            tag_q[in_cm_idx[k*RW +: RW]] == '0) begin
          tag_n[in_cm_idx[k*RW +: RW]] = '0;
        end
      end
    end
    if (in_misbranch) begin
      for (int r = 0; r < NREG; r++) tag_n[r] = '0;
    end else begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (in_dec_rd[i*RW +: RW] != '0 && in_dec_tag[i*TAG_W +: TAG_W] != '0) begin
          tag_n[in_dec_rd[i*RW +: RW]] = in_dec_tag[i*TAG_W +: TAG_W];
        end
      end
    end
    for (int r = 0; r < NREG; r++) begin
      cnt_n = cnt_n + CW'(tag_n[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      cnt_q <= '0;
    end else if (rdy) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= val_n[r];
        tag_q[r] <= tag_n[r];
      end
      cnt_q <= cnt_n;
    end
  end

  assign out_pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Randomized and directed bench for regfile_rename_mp against a per-register behavioural model.
module tb_regfile_rename_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        mis;
  logic [9:0]  in_dec_rs1, in_dec_rs2, in_dec_rd, in_cm_idx;
  logic [7:0]  in_dec_tag, in_cm_tag;
  logic [63:0] in_cm_value;
  logic [63:0] out_rs1_value, out_rs2_value;
  logic [7:0]  out_rs1_tag, out_rs2_tag;
  logic [5:0]  out_pending_cnt;

  logic [4:0]  d_rs1 [2];
  logic [4:0]  d_rs2 [2];
  logic [4:0]  d_rd  [2];
  logic [3:0]  d_tag [2];
  logic [4:0]  c_idx [2];
  logic [3:0]  c_tag [2];
  logic [31:0] c_val [2];

  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];
  int          m_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_dec_rs1[i*5 +: 5]  = d_rs1[i];
      in_dec_rs2[i*5 +: 5]  = d_rs2[i];
      in_dec_rd[i*5 +: 5]   = d_rd[i];
      in_dec_tag[i*4 +: 4]  = d_tag[i];
      in_cm_idx[i*5 +: 5]   = c_idx[i];
      in_cm_tag[i*4 +: 4]   = c_tag[i];
      in_cm_value[i*32 +: 32] = c_val[i];
    end
  end

  regfile_rename_mp dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .in_misbranch    (mis),
    .in_dec_rs1      (in_dec_rs1),
    .in_dec_rs2      (in_dec_rs2),
    .in_dec_rd       (in_dec_rd),
    .in_dec_tag      (in_dec_tag),
    .out_rs1_value   (out_rs1_value),
    .out_rs2_value   (out_rs2_value),
    .out_rs1_tag     (out_rs1_tag),
    .out_rs2_tag     (out_rs2_tag),
    .in_cm_idx       (in_cm_idx),
    .in_cm_value     (in_cm_value),
    .in_cm_tag       (in_cm_tag),
    .out_pending_cnt (out_pending_cnt)
  );

  // Expected {tag, value} for a source of a given slot, from the register-status rules.
  function automatic logic [35:0] ref_read(input int slot, input logic [4:0] idx);
    if (idx == 5'd0) return 36'h0;
    for (int i = slot - 1; i >= 0; i--)
      if (d_rd[i] == idx && d_tag[i] != 4'd0) return {d_tag[i], m_val[idx]};
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (rdy)
      for (int k = 1; k >= 0; k--)
        if (c_idx[k] == idx && c_tag[k] == m_tag[idx]) return {4'd0, c_val[k]};
`endif
    return {m_tag[idx], m_val[idx]};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_val[r] = '0;
      m_tag[r] = '0;
    end
    m_cnt = 0;
  endtask

  // One clock edge: each register independently takes its final value and status.
  task automatic model_edge();
    logic [31:0] nv;
    logic [3:0]  nt;
    if (!rdy) return;
    for (int r = 1; r < 32; r++) begin
      nv = m_val[r];
      nt = m_tag[r];
      for (int k = 0; k < 2; k++)
        if (c_idx[k] == 5'(r)) begin
          nv = c_val[k];
          if (m_tag[r] == c_tag[k] || m_tag[r] == 4'd0) nt = 4'd0;
        end
      if (mis) nt = 4'd0;
      else
        for (int i = 0; i < 2; i++)
          if (d_rd[i] == 5'(r) && d_tag[i] != 4'd0) nt = d_tag[i];
      m_val[r] = nv;
      m_tag[r] = nt;
    end
    m_cnt = 0;
    for (int r = 0; r < 32; r++) if (m_tag[r] != 4'd0) m_cnt++;
  endtask

  task automatic idle();
    rdy = 1'b1;
    mis = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_rs1[i] = '0; d_rs2[i] = '0; d_rd[i] = '0; d_tag[i] = '0;
      c_idx[i] = '0; c_tag[i] = '0; c_val[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    d_rs1[0] = 5'd5; d_rs1[1] = 5'd31; d_rs2[0] = 5'd1; d_rs2[1] = 5'd0;
    #1;
    cmp_cnt++;
    if ({out_rs1_tag, out_rs2_tag} !== 16'h0) begin
      err_cnt++; $display("FAIL reset_tags: got %h expected 0000", {out_rs1_tag, out_rs2_tag});
    end
    cmp_cnt++;
    if ({out_rs1_value, out_rs2_value} !== 128'h0) begin
      err_cnt++; $display("FAIL reset_values: got %h expected 0", {out_rs1_value, out_rs2_value});
    end
    cmp_cnt++;
    if (out_pending_cnt !== 6'd0) begin
      err_cnt++; $display("FAIL reset_pending: got %0d expected 0", out_pending_cnt);
    end
  endtask

  task automatic test_rename_bypass();
    idle();
    d_rd[0] = 5'd5; d_tag[0] = 4'd3; d_rs1[0] = 5'd5; d_rs1[1] = 5'd5;
    #1;
    cmp_cnt++;
    if (out_rs1_tag[7:4] !== 4'd3) begin
      err_cnt++; $display("FAIL bundle_bypass_tag: got %0d expected 3", out_rs1_tag[7:4]);
    end
    cmp_cnt++;
    if (out_rs1_tag[3:0] !== 4'd0) begin
      err_cnt++; $display("FAIL slot0_no_self_bypass: got %0d expected 0", out_rs1_tag[3:0]);
    end
    tick(); idle(); d_rs1[0] = 5'd5;
    #1;
    cmp_cnt++;
    if (out_rs1_tag[3:0] !== 4'd3) begin
      err_cnt++; $display("FAIL rename_state_tag: got %0d expected 3", out_rs1_tag[3:0]);
    end
    cmp_cnt++;
    if (out_pending_cnt !== 6'd1) begin
      err_cnt++; $display("FAIL rename_pending: got %0d expected 1", out_pending_cnt);
    end
  endtask

  task automatic test_commit_tag_match();
    idle(); d_rd[0] = 5'd7; d_tag[0] = 4'd2; tick();
    idle(); d_rd[1] = 5'd7; d_tag[1] = 4'd5; tick();
    idle(); c_idx[0] = 5'd7; c_tag[0] = 4'd2; c_val[0] = 32'hAA; tick();
    idle(); d_rs2[0] = 5'd7;
    #1;
    cmp_cnt++;
    if ({out_rs2_tag[3:0], out_rs2_value[31:0]} !== {4'd5, 32'hAA}) begin
      err_cnt++; $display("FAIL stale_commit: got tag %0d val %h expected tag 5 val aa",
                          out_rs2_tag[3:0], out_rs2_value[31:0]);
    end
    cmp_cnt++;
    if (out_pending_cnt !== 6'd2) begin
      err_cnt++; $display("FAIL stale_commit_pending: got %0d expected 2", out_pending_cnt);
    end
    idle(); c_idx[1] = 5'd7; c_tag[1] = 4'd5; c_val[1] = 32'hBB; tick();
    idle(); d_rs2[0] = 5'd7;
    #1;
    cmp_cnt++;
    if ({out_rs2_tag[3:0], out_rs2_value[31:0]} !== {4'd0, 32'hBB}) begin
      err_cnt++; $display("FAIL match_commit: got tag %0d val %h expected tag 0 val bb",
                          out_rs2_tag[3:0], out_rs2_value[31:0]);
    end
    cmp_cnt++;
    if (out_pending_cnt !== 6'd1) begin
      err_cnt++; $display("FAIL match_commit_pending: got %0d expected 1", out_pending_cnt);
    end
  endtask

  task automatic test_rename_vs_commit();
    idle(); d_rd[1] = 5'd9; d_tag[1] = 4'd4; tick();
    idle(); c_idx[0] = 5'd9; c_tag[0] = 4'd4; c_val[0] = 32'h99;
    d_rd[0] = 5'd9; d_tag[0] = 4'd6; tick();
    idle(); d_rs1[1] = 5'd9;
    #1;
    cmp_cnt++;
    if ({out_rs1_tag[7:4], out_rs1_value[63:32]} !== {4'd6, 32'h99}) begin
      err_cnt++; $display("FAIL rename_beats_commit: got tag %0d val %h expected tag 6 val 99",
                          out_rs1_tag[7:4], out_rs1_value[63:32]);
    end
    cmp_cnt++;
    if (out_pending_cnt !== 6'd2) begin
      err_cnt++; $display("FAIL rename_commit_pending: got %0d expected 2", out_pending_cnt);
    end
  endtask

  task automatic test_misbranch_rdy();
    idle(); d_rd[0] = 5'd1; d_tag[0] = 4'd1; d_rd[1] = 5'd2; d_tag[1] = 4'd2; tick();
    idle(); d_rd[0] = 5'd3; d_tag[0] = 4'd3; d_rd[1] = 5'd4; d_tag[1] = 4'd8; tick();
    for (int pass = 0; pass < 2; pass++) begin
      idle(); rdy = (pass == 1); mis = 1'b1;
      c_idx[0] = 5'd2; c_val[0] = 32'h11; d_rd[0] = 5'd10; d_tag[0] = 4'd1;
      tick();
      idle(); d_rs1[0] = 5'd2; d_rs2[0] = 5'd4; d_rs1[1] = 5'd10;
      #1;
      if (pass == 0) begin
        cmp_cnt++;
        if ({out_rs1_tag[3:0], out_rs1_value[31:0], out_rs2_tag[3:0]} !== {4'd2, 32'h0, 4'd8}) begin
          err_cnt++; $display("FAIL rdy_low_hold: got x2 %0d/%h x4 tag %0d expected 2/0 8",
                              out_rs1_tag[3:0], out_rs1_value[31:0], out_rs2_tag[3:0]);
        end
        cmp_cnt++;
        if (out_pending_cnt !== 6'd6) begin
          err_cnt++; $display("FAIL rdy_low_pending: got %0d expected 6", out_pending_cnt);
        end
      end else begin
        cmp_cnt++;
        if ({out_rs1_tag[3:0], out_rs1_value[31:0], out_rs2_tag[3:0], out_rs1_tag[7:4]}
            !== {4'd0, 32'h11, 4'd0, 4'd0}) begin
          err_cnt++; $display("FAIL flush_state: got x2 %0d/%h x4 %0d x10 %0d expected 0/11 0 0",
                              out_rs1_tag[3:0], out_rs1_value[31:0], out_rs2_tag[3:0], out_rs1_tag[7:4]);
        end
        cmp_cnt++;
        if (out_pending_cnt !== 6'd0) begin
          err_cnt++; $display("FAIL flush_pending: got %0d expected 0", out_pending_cnt);
        end
      end
    end
  endtask

  task automatic test_commit_bypass();
    idle(); d_rd[0] = 5'd3; d_tag[0] = 4'd7; tick();
    idle(); c_idx[1] = 5'd3; c_tag[1] = 4'd7; c_val[1] = 32'h55; d_rs1[0] = 5'd3;
    #1;
    cmp_cnt++;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if ({out_rs1_tag[3:0], out_rs1_value[31:0]} !== {4'd0, 32'h55}) begin
      err_cnt++; $display("FAIL commit_forward: got %0d/%h expected 0/55",
                          out_rs1_tag[3:0], out_rs1_value[31:0]);
    end
`else
    if ({out_rs1_tag[3:0], out_rs1_value[31:0]} !== {4'd7, 32'h0}) begin
      err_cnt++; $display("FAIL no_commit_forward: got %0d/%h expected 7/0",
                          out_rs1_tag[3:0], out_rs1_value[31:0]);
    end
`endif
    tick(); idle(); d_rs1[0] = 5'd3;
    #1;
    cmp_cnt++;
    if ({out_rs1_tag[3:0], out_rs1_value[31:0], out_pending_cnt} !== {4'd0, 32'h55, 6'd0}) begin
      err_cnt++; $display("FAIL commit_next_cycle: got %0d/%h cnt %0d expected 0/55 cnt 0",
                          out_rs1_tag[3:0], out_rs1_value[31:0], out_pending_cnt);
    end
  endtask

  task automatic test_random();
    logic [35:0] exp;
    for (int n = 0; n < 300; n++) begin
      idle();
      rdy = ($urandom_range(0, 99) < 85);
      mis = ($urandom_range(0, 99) < 5);
      for (int i = 0; i < 2; i++) begin
        d_rs1[i] = 5'($urandom_range(0, 7));
        d_rs2[i] = 5'($urandom_range(0, 31));
        d_rd[i]  = 5'($urandom_range(0, 7));
        d_tag[i] = 4'($urandom_range(0, 15));
        c_idx[i] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
        c_tag[i] = $urandom_range(0, 1) ? m_tag[c_idx[i]] : 4'($urandom_range(0, 15));
        c_val[i] = $urandom;
      end
      #1;
      for (int s = 0; s < 2; s++) begin
        exp = ref_read(s, d_rs1[s]);
        cmp_cnt++;
        if ({out_rs1_tag[s*4 +: 4], out_rs1_value[s*32 +: 32]} !== exp) begin
          err_cnt++; $display("FAIL rand_rs1 cyc %0d slot %0d: got %h expected %h", n, s,
                              {out_rs1_tag[s*4 +: 4], out_rs1_value[s*32 +: 32]}, exp);
        end
        exp = ref_read(s, d_rs2[s]);
        cmp_cnt++;
        if ({out_rs2_tag[s*4 +: 4], out_rs2_value[s*32 +: 32]} !== exp) begin
          err_cnt++; $display("FAIL rand_rs2 cyc %0d slot %0d: got %h expected %h", n, s,
                              {out_rs2_tag[s*4 +: 4], out_rs2_value[s*32 +: 32]}, exp);
        end
      end
      tick();
      cmp_cnt++;
      if (out_pending_cnt !== 6'(m_cnt)) begin
        err_cnt++; $display("FAIL rand_pending cyc %0d: got %0d expected %0d", n, out_pending_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    idle(); d_rd[0] = 5'd5; d_tag[0] = 4'd3; d_rd[1] = 5'd6; d_tag[1] = 4'd9; tick();
    idle(); d_rs1[0] = 5'd5; d_rs1[1] = 5'd6;
    #1;
    cmp_cnt++;
    if (out_rs1_tag !== 8'h93) begin
      err_cnt++; $display("FAIL pre_reset_tags: got %h expected 93", out_rs1_tag);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp_cnt++;
    if ({out_rs1_tag, out_rs1_value, out_pending_cnt} !== 78'h0) begin
      err_cnt++; $display("FAIL async_reset: got tags %h vals %h cnt %0d expected all 0",
                          out_rs1_tag, out_rs1_value, out_pending_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    cmp_cnt++;
    if ({out_rs1_tag, out_rs1_value, out_pending_cnt} !== 78'h0) begin
      err_cnt++; $display("FAIL post_reset: got tags %h vals %h cnt %0d expected all 0",
                          out_rs1_tag, out_rs1_value, out_pending_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    idle();
    rst_n = 1'b1;
    tick();
    test_rename_bypass();
    test_commit_tag_match();
    test_rename_vs_commit();
    test_misbranch_rdy();
    test_commit_bypass();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
